// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 receiver shared types, prefix constants and parity helper
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    // One FIFO entry: prefix flags travel with the scan-code byte
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] data;
    } ps2_code_t;

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd count of ones
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_rx_filter.sv
// rtl/ps2_rx_filter.sv - two-flop synchroniser plus debounce for one PS/2 line
module ps2_rx_filter #(
    parameter int DEBOUNCE_CYCLES = 19
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filt
);

    localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Bring the asynchronous line into the clk domain; idle level of the bus is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], raw};
        end
    end

    // Follow the synchronised line only after it has disagreed for DEBOUNCE_CYCLES in a row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt <= 1'b1;
            cnt  <= '0;
        end else if (sync[1] == filt) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            filt <= sync[1];
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 frame receiver with scan-code FIFO; optional prefix decode via PS2_RX_BREAK_DECODE_EN
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 19,
    parameter int TIMEOUT_CYCLES  = 100000,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code_data,
    output logic       code_ext,
    output logic       code_brk,
    output logic       code_valid,
    input  logic       code_ready,
    output logic       err_parity,
    output logic       err_frame,
    output logic       ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic clk_f;
    logic data_f;
    logic clk_f_q;
    logic fall;

    ps2_state_t state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       par_ok;
    logic [TW-1:0] tmo_cnt;

    logic      stop_fall;
    logic      frame_ok;
    logic      timeout;
    logic      push;
    ps2_code_t push_code;

    ps2_code_t mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_n;
    logic [PW-1:0] rd_ptr_n;
    logic          full;
    logic          do_push;
    logic          do_pop;
    ps2_code_t     head_nxt;

    ps2_rx_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clk_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (ps2_clk),
        .filt  (clk_f)
    );

    ps2_rx_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_data_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (ps2_data),
        .filt  (data_f)
    );

    // Remember the previous filtered clock so a 1->0 transition can be seen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_f_q <= 1'b1;
        end else begin
            clk_f_q <= clk_f;
        end
    end

    assign fall      = clk_f_q & ~clk_f;
    assign stop_fall = fall && (state == ST_STOP);
    assign frame_ok  = stop_fall && data_f && par_ok;
    assign timeout   = (state != ST_IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

`ifdef PS2_RX_BREAK_DECODE_EN
    logic pend_ext;
    logic pend_brk;
    logic is_ext;
    logic is_brk;

    assign is_ext    = (shreg == PS2_PREFIX_EXT);
    assign is_brk    = (shreg == PS2_PREFIX_BRK);
    assign push      = frame_ok && !is_ext && !is_brk;
    assign push_code = '{ext: pend_ext, brk: pend_brk, data: shreg};

    // Prefix bytes arm flags for the next real code; any frame failure forgets them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_ext <= 1'b0;
            pend_brk <= 1'b0;
        end else if (timeout || (stop_fall && !(data_f && par_ok))) begin
            pend_ext <= 1'b0;
            pend_brk <= 1'b0;
        end else if (frame_ok) begin
            if (is_ext) begin
                pend_ext <= 1'b1;
            end else if (is_brk) begin
                pend_brk <= 1'b1;
            end else begin
                pend_ext <= 1'b0;
                pend_brk <= 1'b0;
            end
        end
    end
`else
    assign push      = frame_ok;
    assign push_code = '{ext: 1'b0, brk: 1'b0, data: shreg};
`endif

    // Frame FSM: start, 8 data bits LSB first, odd parity, stop; watchdog aborts stalled frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_ok     <= 1'b0;
            tmo_cnt    <= '0;
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
        end else begin
            err_parity <= 1'b0;
            err_frame  <= 1'b0;

            if (fall || (state == ST_IDLE) || timeout) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (timeout) begin
                state     <= ST_IDLE;
                err_frame <= 1'b1;
            end else if (fall) begin
                case (state)
                    ST_IDLE: begin
                        if (!data_f) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        shreg   <= {data_f, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_ok <= odd_parity_ok(shreg, data_f);
                        state  <= ST_STOP;
                    end
                    ST_STOP: begin
                        state <= ST_IDLE;
                        if (!data_f) begin
                            err_frame <= 1'b1;
                        end else if (!par_ok) begin
                            err_parity <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = code_valid && code_ready;
    assign do_push  = push && (!full || do_pop);
    assign wr_ptr_n = wr_ptr + PW'(do_push);
    assign rd_ptr_n = rd_ptr + PW'(do_pop);

    // Next head entry; bypass the write when the new head is the slot being filled now
    always_comb begin
        head_nxt = mem[rd_ptr_n[AW-1:0]];
        if (do_push && (rd_ptr_n == wr_ptr)) begin
            head_nxt = push_code;
        end
    end

    // FIFO storage needs no reset: only entries between the pointers are ever shown
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_code;
        end
    end

    // Pointers and registered head; outputs hold their last value while empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            code_valid <= 1'b0;
            code_data  <= '0;
            code_ext   <= 1'b0;
            code_brk   <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_n;
            rd_ptr     <= rd_ptr_n;
            code_valid <= (wr_ptr_n != rd_ptr_n);
            ovf        <= push && full && !do_pop;
            if (wr_ptr_n != rd_ptr_n) begin
                code_data <= head_nxt.data;
                code_ext  <= head_nxt.ext;
                code_brk  <= head_nxt.brk;
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - directed self-checking bench for ps2_rx_fifo
module tb_ps2_rx_fifo;
    import ps2_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] code_data;
    logic       code_ext;
    logic       code_brk;
    logic       code_valid;
    logic       code_ready = 1'b0;
    logic       err_parity;
    logic       err_frame;
    logic       ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int n_perr   = 0;
    int n_ferr   = 0;
    int n_ovf    = 0;
    logic [9:0] rxq [$];

    always #5 clk = ~clk;

    ps2_rx_fifo #(
        .DEBOUNCE_CYCLES (3),
        .TIMEOUT_CYCLES  (200),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .code_data  (code_data),
        .code_ext   (code_ext),
        .code_brk   (code_brk),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .err_parity (err_parity),
        .err_frame  (err_frame),
        .ovf        (ovf)
    );

    // Record popped entries {ext,brk,data} and count error pulses away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (code_valid && code_ready) rxq.push_back({code_ext, code_brk, code_data});
            if (err_parity) n_perr++;
            if (err_frame)  n_ferr++;
            if (ovf)        n_ovf++;
        end
    end

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1 code_ready = r;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (5) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (10) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((~^d) ^ bad_par);
        send_bit(~bad_stop);
        ps2_data = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    task automatic check_entry(input string name, input logic [9:0] exp);
        logic [9:0] got;
        n_checks++;
        if (rxq.size() == 0) begin
            $display("FAIL %s: no entry received, expected %h", name, exp);
            n_fail++;
        end else begin
            got = rxq.pop_front();
            if (got !== exp) begin
                $display("FAIL %s: got {ext,brk,data}=%h expected %h", name, got, exp);
                n_fail++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (code_valid !== 1'b0) begin $display("FAIL reset_valid: got %b expected 0", code_valid); n_fail++; end
        n_checks++;
        if ({code_ext, code_brk, code_data} !== 10'h000) begin
            $display("FAIL reset_code: got %h expected 000", {code_ext, code_brk, code_data}); n_fail++;
        end
        n_checks++;
        if ({err_parity, err_frame, ovf} !== 3'b000) begin
            $display("FAIL reset_pulses: got %b expected 000", {err_parity, err_frame, ovf}); n_fail++;
        end
        n_checks++;
        if (dut.state !== ST_IDLE) begin $display("FAIL reset_state: got %0d expected IDLE", dut.state); n_fail++; end
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_basic();
        set_ready(1'b1);
        send_frame(8'h1C, 1'b0, 1'b0);
        n_checks++;
        if (rxq.size() != 1) begin $display("FAIL basic_count: got %0d expected 1", rxq.size()); n_fail++; end
        check_entry("basic_1c", 10'h01C);
    endtask

    task automatic test_idle_glitch();
        int p0 = n_perr;
        int f0 = n_ferr;
        send_bit(1'b1);
        repeat (10) @(posedge clk);
        n_checks++;
        if ((n_perr - p0) != 0 || (n_ferr - f0) != 0 || rxq.size() != 0) begin
            $display("FAIL idle_glitch: perr=%0d ferr=%0d entries=%0d expected 0 0 0",
                     n_perr - p0, n_ferr - f0, rxq.size());
            n_fail++;
        end
    endtask

    task automatic test_parity();
        int p0 = n_perr;
        int f0 = n_ferr;
        send_frame(8'h1C, 1'b1, 1'b0);
        n_checks++;
        if ((n_perr - p0) != 1) begin $display("FAIL parity_pulse: got %0d expected 1", n_perr - p0); n_fail++; end
        n_checks++;
        if ((n_ferr - f0) != 0) begin $display("FAIL parity_noframe: got %0d expected 0", n_ferr - f0); n_fail++; end
        n_checks++;
        if (rxq.size() != 0) begin $display("FAIL parity_nopush: got %0d expected 0", rxq.size()); n_fail++; end
        send_frame(8'h1C, 1'b0, 1'b0);
        check_entry("parity_recover", 10'h01C);
    endtask

    task automatic test_bad_stop();
        int p0 = n_perr;
        int f0 = n_ferr;
        send_frame(8'h5A, 1'b1, 1'b1);
        n_checks++;
        if ((n_ferr - f0) != 1 || (n_perr - p0) != 0) begin
            $display("FAIL stop_frame: ferr=%0d perr=%0d expected 1 0", n_ferr - f0, n_perr - p0); n_fail++;
        end
        n_checks++;
        if (rxq.size() != 0) begin $display("FAIL stop_nopush: got %0d expected 0", rxq.size()); n_fail++; end
    endtask

    task automatic test_prefix();
`ifdef PS2_RX_BREAK_DECODE_EN
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        n_checks++;
        if (rxq.size() != 1) begin $display("FAIL brk_count: got %0d expected 1", rxq.size()); n_fail++; end
        check_entry("brk_1c", 10'h11C);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        n_checks++;
        if (rxq.size() != 1) begin $display("FAIL extbrk_count: got %0d expected 1", rxq.size()); n_fail++; end
        check_entry("extbrk_75", 10'h375);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        check_entry("prefix_cleared", 10'h022);
`else
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        n_checks++;
        if (rxq.size() != 2) begin $display("FAIL raw_count: got %0d expected 2", rxq.size()); n_fail++; end
        check_entry("raw_f0", 10'h0F0);
        check_entry("raw_1c", 10'h01C);
`endif
    endtask

    task automatic test_overflow();
        int o0 = n_ovf;
        set_ready(1'b0);
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b0);
        n_checks++;
        if ((n_ovf - o0) != 0) begin $display("FAIL ovf_early: got %0d expected 0", n_ovf - o0); n_fail++; end
        n_checks++;
        if (code_valid !== 1'b1 || code_data !== 8'h01) begin
            $display("FAIL ovf_head: valid=%b data=%h expected 1 01", code_valid, code_data); n_fail++;
        end
        send_frame(8'h05, 1'b0, 1'b0);
        n_checks++;
        if ((n_ovf - o0) != 1) begin $display("FAIL ovf_pulse: got %0d expected 1", n_ovf - o0); n_fail++; end
        set_ready(1'b1);
        repeat (10) @(posedge clk);
        n_checks++;
        if (rxq.size() != 4) begin $display("FAIL ovf_drain_count: got %0d expected 4", rxq.size()); n_fail++; end
        for (int i = 1; i <= 4; i++) check_entry("ovf_drain", {2'b00, 8'(i)});
        #1;
        n_checks++;
        if (code_valid !== 1'b0 || code_data !== 8'h04) begin
            $display("FAIL empty_hold: valid=%b data=%h expected 0 04", code_valid, code_data); n_fail++;
        end
    endtask

    task automatic test_timeout();
        int f0 = n_ferr;
        logic [7:0] d = 8'h2A;
        send_bit(1'b0);
        for (int i = 0; i < 6; i++) send_bit(d[i]);
        repeat (300) @(posedge clk);
        n_checks++;
        if ((n_ferr - f0) != 1) begin $display("FAIL timeout_pulse: got %0d expected 1", n_ferr - f0); n_fail++; end
        n_checks++;
        if (dut.state !== ST_IDLE) begin $display("FAIL timeout_idle: got %0d expected IDLE", dut.state); n_fail++; end
        ps2_data = 1'b1;
        repeat (10) @(posedge clk);
        send_frame(8'h2A, 1'b0, 1'b0);
        n_checks++;
        if (rxq.size() != 1) begin $display("FAIL timeout_count: got %0d expected 1", rxq.size()); n_fail++; end
        check_entry("timeout_2a", 10'h02A);
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d = 8'h33;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({code_valid, code_ext, code_brk, code_data, err_parity, err_frame, ovf} !== 14'h0) begin
            $display("FAIL midreset_outputs: got %h expected 0",
                     {code_valid, code_ext, code_brk, code_data, err_parity, err_frame, ovf});
            n_fail++;
        end
        ps2_data = 1'b1;
        repeat (20) @(posedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        send_frame(8'h33, 1'b0, 1'b0);
        n_checks++;
        if (rxq.size() != 1) begin $display("FAIL midreset_count: got %0d expected 1", rxq.size()); n_fail++; end
        check_entry("midreset_33", 10'h033);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_idle_glitch();
        test_parity();
        test_bad_stop();
        test_prefix();
        test_overflow();
        test_timeout();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
